// File: rtl/pid_sequencer.sv
// pid_sequencer: sequences one PID computation per control tick and latches its throttle result.
// It also tracks stale-sample, timeout and overrun conditions.
`default_nettype none

module pid_sequencer (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               tick,
  input  logic               sensor_valid,
  input  logic signed [15:0] sensor_data,
  input  logic               cmd_valid,
  input  logic [7:0]         cmd,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_data,
  input  logic               pid_done,
  input  logic [14:0]        pid_result,
  output logic               pid_reset,
  output logic               pid_start,
  output logic [7:0]         pid_command,
  output logic signed [15:0] pid_data,
  output logic [7:0]         pid_kp,
  output logic [7:0]         pid_ki,
  output logic [7:0]         pid_kd,
  output logic               out_valid,
  output logic [14:0]        out_throttle,
  output logic               stale_fault,
  output logic               timeout_fault,
  output logic [7:0]         overrun_cnt
);

  typedef enum logic [2:0] {
    S_DISABLED = 3'd0,
    S_IDLE     = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT     = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam logic [7:0] KP_RESET = 8'd16;
  localparam logic [3:0] WAIT_LAST = 4'd15;
  localparam logic [2:0] MISS_LIMIT = 3'd4;

  state_t             state_q;
  logic               fresh_q;
  logic [2:0]         miss_q;
  logic [3:0]         wait_q;
  logic signed [15:0] sample_q;
  logic [7:0]         cmd_q;
  logic [7:0]         kp_sh_q, ki_sh_q, kd_sh_q;
  logic               pid_start_q;
  logic [7:0]         pid_cmd_q;
  logic signed [15:0] pid_data_q;
  logic [7:0]         pid_kp_q, pid_ki_q, pid_kd_q;
  logic               out_valid_q;
  logic [14:0]        throttle_q;
  logic               stale_q, timeout_q;
  logic [7:0]         overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_DISABLED;
      fresh_q     <= 1'b0;
      miss_q      <= '0;
      wait_q      <= '0;
      sample_q    <= '0;
      cmd_q       <= '0;
      kp_sh_q     <= KP_RESET;
      ki_sh_q     <= '0;
      kd_sh_q     <= '0;
      pid_start_q <= 1'b0;
      pid_cmd_q   <= '0;
      pid_data_q  <= '0;
      pid_kp_q    <= KP_RESET;
      pid_ki_q    <= '0;
      pid_kd_q    <= '0;
      out_valid_q <= 1'b0;
      throttle_q  <= '0;
      stale_q     <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= '0;
    end else begin
      pid_start_q <= 1'b0;
      out_valid_q <= 1'b0;

      if (cmd_valid) cmd_q <= cmd;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    kp_sh_q <= cfg_data;
          2'd1:    ki_sh_q <= cfg_data;
          2'd2:    kd_sh_q <= cfg_data;
          default: ;
        endcase
      end

      // Ticks that arrive while a request is in flight are dropped, only counted.
      if (tick && (state_q == S_ISSUE || state_q == S_WAIT) && overrun_q != 8'hFF)
        overrun_q <= overrun_q + 8'd1;

      case (state_q)
        S_DISABLED: begin
          throttle_q <= '0;
          if (enable) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (!enable) begin
            state_q    <= S_DISABLED;
            throttle_q <= '0;
          end else if (tick) begin
            if (fresh_q) begin
              state_q     <= S_ISSUE;
              fresh_q     <= 1'b0;
              miss_q      <= '0;
              pid_start_q <= 1'b1;
              pid_cmd_q   <= cmd_q;
              pid_data_q  <= sample_q;
              pid_kp_q    <= kp_sh_q;
              pid_ki_q    <= ki_sh_q;
              pid_kd_q    <= kd_sh_q;
            end else if (miss_q == MISS_LIMIT - 3'd1) begin
              miss_q     <= MISS_LIMIT;
              stale_q    <= 1'b1;
              throttle_q <= '0;
              state_q    <= S_FAULT;
            end else begin
              miss_q <= miss_q + 3'd1;
            end
          end
        end
        S_ISSUE: begin
          if (!enable) begin
            state_q    <= S_DISABLED;
            throttle_q <= '0;
          end else begin
            state_q <= S_WAIT;
            wait_q  <= '0;
          end
        end
        S_WAIT: begin
          // Completion on the last allowed cycle takes priority over the timeout.
          if (!enable) begin
            state_q    <= S_DISABLED;
            throttle_q <= '0;
          end else if (pid_done) begin
            throttle_q  <= pid_result;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (wait_q == WAIT_LAST) begin
            timeout_q  <= 1'b1;
            throttle_q <= '0;
            state_q    <= S_FAULT;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        S_FAULT: begin
          throttle_q <= '0;
          if (!enable) begin
            state_q   <= S_DISABLED;
            stale_q   <= 1'b0;
            timeout_q <= 1'b0;
            miss_q    <= '0;
          end
        end
        default: state_q <= S_DISABLED;
      endcase

      // A sample arriving alongside an issue is not the one being issued, so it stays fresh.
      if (sensor_valid) begin
        sample_q <= sensor_data;
        fresh_q  <= 1'b1;
      end
    end
  end

  assign pid_reset     = (state_q == S_DISABLED) || (state_q == S_FAULT);
  assign pid_start     = pid_start_q;
  assign pid_command   = pid_cmd_q;
  assign pid_data      = pid_data_q;
  assign pid_kp        = pid_kp_q;
  assign pid_ki        = pid_ki_q;
  assign pid_kd        = pid_kd_q;
  assign out_valid     = out_valid_q;
  assign out_throttle  = throttle_q;
  assign stale_fault   = stale_q;
  assign timeout_fault = timeout_q;
  assign overrun_cnt   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pid_sequencer.sv
// tb_pid_sequencer: directed scenarios plus random traffic, every cycle checked against a behavioural model.
`default_nettype none

module tb_pid_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1, enable = 1'b0, tick = 1'b0;
  logic        sensor_valid = 1'b0, cmd_valid = 1'b0, cfg_we = 1'b0, pid_done = 1'b0;
  logic [15:0] sensor_data = '0;
  logic [7:0]  cmd = '0, cfg_data = '0;
  logic [1:0]  cfg_addr = '0;
  logic [14:0] pid_result = '0;

  logic        pid_reset, pid_start, out_valid, stale_fault, timeout_fault;
  logic [7:0]  pid_command, pid_kp, pid_ki, pid_kd, overrun_cnt;
  logic [15:0] pid_data;
  logic [14:0] out_throttle;

  int checks = 0;
  int failures = 0;
  int starts;

  // Behavioural model: loop mode flags plus the age of the outstanding request
  // (-1 none, 0 the issue cycle, 1..16 waiting cycles).
  bit          m_dis, m_flt, m_fresh, m_start, m_valid, m_stale, m_timeout;
  int          m_age, m_miss, m_over;
  logic [15:0] m_sample, m_pid_data;
  logic [7:0]  m_cmd, m_pid_cmd, m_kp, m_ki, m_kd;
  logic [7:0]  m_sh [3];
  logic [14:0] m_throttle;

  pid_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick),
    .sensor_valid(sensor_valid), .sensor_data(sensor_data),
    .cmd_valid(cmd_valid), .cmd(cmd),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pid_done(pid_done), .pid_result(pid_result),
    .pid_reset(pid_reset), .pid_start(pid_start),
    .pid_command(pid_command), .pid_data(pid_data),
    .pid_kp(pid_kp), .pid_ki(pid_ki), .pid_kd(pid_kd),
    .out_valid(out_valid), .out_throttle(out_throttle),
    .stale_fault(stale_fault), .timeout_fault(timeout_fault),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dis = 1; m_flt = 0; m_fresh = 0; m_start = 0; m_valid = 0;
    m_stale = 0; m_timeout = 0; m_age = -1; m_miss = 0; m_over = 0;
    m_sample = '0; m_pid_data = '0; m_cmd = '0; m_pid_cmd = '0;
    m_sh[0] = 8'd16; m_sh[1] = '0; m_sh[2] = '0;
    m_kp = 8'd16; m_ki = '0; m_kd = '0; m_throttle = '0;
  endtask

  task automatic model_edge();
    bit busy;
    if (reset) begin
      model_reset();
      return;
    end
    busy = !m_dis && !m_flt && m_age >= 0;
    m_start = 0;
    m_valid = 0;
    if (busy && tick && m_over < 255) m_over++;
    if (m_flt) begin
      if (!enable) begin
        m_flt = 0; m_dis = 1; m_stale = 0; m_timeout = 0; m_miss = 0;
      end
    end else if (m_dis) begin
      if (enable) m_dis = 0;
    end else if (!enable) begin
      m_dis = 1; m_throttle = '0; m_age = -1;
    end else if (m_age < 0) begin
      if (tick) begin
        if (m_fresh) begin
          m_start = 1; m_pid_cmd = m_cmd; m_pid_data = m_sample;
          m_kp = m_sh[0]; m_ki = m_sh[1]; m_kd = m_sh[2];
          m_fresh = 0; m_miss = 0; m_age = 0;
        end else begin
          m_miss++;
          if (m_miss == 4) begin
            m_flt = 1; m_stale = 1; m_throttle = '0;
          end
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (pid_done) begin
      m_throttle = pid_result; m_valid = 1; m_age = -1;
    end else if (m_age == 16) begin
      m_flt = 1; m_timeout = 1; m_throttle = '0; m_age = -1;
    end else begin
      m_age++;
    end
    if (sensor_valid) begin
      m_sample = sensor_data;
      m_fresh = 1;
    end
    if (cmd_valid) m_cmd = cmd;
    if (cfg_we && cfg_addr != 2'd3) m_sh[cfg_addr] = cfg_data;
  endtask

  task automatic compare_all();
    chk("pid_reset", {31'd0, pid_reset}, {31'd0, (m_dis || m_flt)});
    chk("pid_start", {31'd0, pid_start}, {31'd0, m_start});
    chk("pid_command", {24'd0, pid_command}, {24'd0, m_pid_cmd});
    chk("pid_data", {16'd0, pid_data}, {16'd0, m_pid_data});
    chk("pid_kp", {24'd0, pid_kp}, {24'd0, m_kp});
    chk("pid_ki", {24'd0, pid_ki}, {24'd0, m_ki});
    chk("pid_kd", {24'd0, pid_kd}, {24'd0, m_kd});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_throttle", {17'd0, out_throttle}, {17'd0, m_throttle});
    chk("stale_fault", {31'd0, stale_fault}, {31'd0, m_stale});
    chk("timeout_fault", {31'd0, timeout_fault}, {31'd0, m_timeout});
    chk("overrun_cnt", {24'd0, overrun_cnt}, m_over);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    tick = 0; sensor_valid = 0; cmd_valid = 0; cfg_we = 0; pid_done = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #1;
    steps(2);
    reset = 0;
    chk("rst_pid_reset", {31'd0, pid_reset}, 32'd1);
    chk("rst_kp", {24'd0, pid_kp}, 32'd16);
    chk("rst_overrun", {24'd0, overrun_cnt}, 32'd0);

    // Basic transaction
    enable = 1; step();
    cmd_valid = 1; cmd = 8'd100; sensor_valid = 1; sensor_data = 16'd1500; step();
    tick = 1; step();
    chk("basic_start", {31'd0, pid_start}, 32'd1);
    chk("basic_cmd", {24'd0, pid_command}, 32'd100);
    chk("basic_data", {16'd0, pid_data}, 32'd1500);
    chk("basic_kp", {24'd0, pid_kp}, 32'd16);
    step();
    cfg_we = 1; cfg_addr = 2'd0; cfg_data = 8'd40; step();
    chk("shadow_kp_hold", {24'd0, pid_kp}, 32'd16);
    pid_done = 1; pid_result = 15'd320; step();
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_throttle", {17'd0, out_throttle}, 32'd320);
    step();
    chk("valid_pulse", {31'd0, out_valid}, 32'd0);

    // New gain at next issue; completion on the 16th cycle after start
    sensor_valid = 1; sensor_data = 16'hFF38; step();
    tick = 1; step();
    chk("next_kp", {24'd0, pid_kp}, 32'd40);
    chk("neg_data", {16'd0, pid_data}, 32'h0000FF38);
    steps(16);
    pid_done = 1; pid_result = 15'd7; step();
    chk("edge_valid", {31'd0, out_valid}, 32'd1);
    chk("edge_no_timeout", {31'd0, timeout_fault}, 32'd0);

    // Timeout
    sensor_valid = 1; sensor_data = 16'd900; step();
    tick = 1; step();
    steps(17);
    chk("timeout_flag", {31'd0, timeout_fault}, 32'd1);
    chk("timeout_reset", {31'd0, pid_reset}, 32'd1);
    chk("timeout_throttle", {17'd0, out_throttle}, 32'd0);
    pid_done = 1; step();
    chk("done_ignored", {31'd0, out_valid}, 32'd0);
    enable = 0; step();
    chk("timeout_clear", {31'd0, timeout_fault}, 32'd0);
    enable = 1; step();

    // Stale samples
    for (int i = 0; i < 4; i++) begin
      tick = 1; step(); step();
    end
    chk("stale_flag", {31'd0, stale_fault}, 32'd1);
    chk("stale_reset", {31'd0, pid_reset}, 32'd1);
    chk("stale_throttle", {17'd0, out_throttle}, 32'd0);
    enable = 0; step();
    chk("stale_clear", {31'd0, stale_fault}, 32'd0);
    enable = 1; step();

    // Overrun saturation: 16 busy ticks per round, 20 rounds
    starts = 0;
    for (int r = 0; r < 20; r++) begin
      sensor_valid = 1; sensor_data = 16'(r); step();
      tick = 1; step();
      starts += int'(pid_start);
      for (int i = 0; i < 15; i++) begin
        tick = 1; step();
        starts += int'(pid_start);
      end
      tick = 1; pid_done = 1; step();
      starts += int'(pid_start);
    end
    chk("overrun_sat", {24'd0, overrun_cnt}, 32'd255);
    chk("overrun_starts", starts, 32'd20);

    // Reset mid-wait
    sensor_valid = 1; cmd_valid = 1; cmd = 8'd55; step();
    tick = 1; step();
    step();
    reset = 1; step();
    reset = 0; pid_done = 1; pid_result = 15'd99; step();
    chk("rst_wait_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wait_cmd", {24'd0, pid_command}, 32'd0);
    chk("rst_wait_throttle", {17'd0, out_throttle}, 32'd0);
    chk("rst_wait_overrun", {24'd0, overrun_cnt}, 32'd0);

    // Random traffic
    enable = 1;
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 999) < 4);
      enable       = ($urandom_range(0, 99) < 96);
      tick         = ($urandom_range(0, 99) < 20);
      sensor_valid = ($urandom_range(0, 99) < 30);
      sensor_data  = 16'($urandom);
      cmd_valid    = ($urandom_range(0, 99) < 10);
      cmd          = 8'($urandom);
      cfg_we       = ($urandom_range(0, 99) < 10);
      cfg_addr     = 2'($urandom);
      cfg_data     = 8'($urandom);
      pid_done     = ($urandom_range(0, 99) < 12);
      pid_result   = 15'($urandom);
      step();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pid_sequencer.md
PID_SEQUENCER -- requirements
Module: pid_sequencer

Interface
REQ-001 Interface SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-002 clk  in  1  system clock, all logic rising-edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 enable  in  1  control loop enable; 0 forces disabled state.
REQ-005 tick  in  1  one-cycle control-period strobe.
REQ-006 sensor_valid / sensor_data  in  1 / 16 signed  altitude sample in mm, accepted when valid=1.
REQ-007 cmd_valid / cmd  in  1 / 8  setpoint update, accepted when valid=1.
REQ-008 cfg_we / cfg_addr / cfg_data  in  1 / 2 / 8  shadow gain write; addr 0=kp, 1=ki, 2=kd, 3=ignored.
REQ-009 pid_done / pid_result  in  1 / 15  PID completion strobe and throttle result.
REQ-010 pid_reset  out  1  holds the PID datapath in reset.
REQ-011 pid_start  out  1  one-cycle PID data-valid strobe.
REQ-012 pid_command / pid_data  out  8 / 16 signed  snapshot presented to PID.
REQ-013 pid_kp / pid_ki / pid_kd  out  8 each  active gains presented to PID.
REQ-014 out_valid / out_throttle  out  1 / 15  result strobe and held throttle.
REQ-015 stale_fault / timeout_fault  out  1 each  sticky fault flags.
REQ-016 overrun_cnt  out  8  saturating count of ticks lost while busy.

Function
REQ-017 FSM states SHALL be DISABLED, IDLE, ISSUE, WAIT, FAULT.
REQ-018 DISABLED: pid_reset=1, out_throttle=0; enable=1 -> IDLE next cycle.
REQ-019 Any state other than FAULT with enable=0 -> DISABLED next cycle, pid_start suppressed.
REQ-020 sensor_valid SHALL latch sensor_data and set fresh flag; cmd_valid SHALL latch cmd; both accepted in every state.
REQ-021 cfg_we SHALL update shadow gains only; active gains change only on entry to ISSUE, atomically for all three.
REQ-022 IDLE + tick + fresh=1 -> ISSUE; fresh cleared, miss counter cleared.
REQ-023 IDLE + tick + fresh=0 -> miss counter +1; at 4 consecutive misses set stale_fault -> FAULT.
REQ-024 ISSUE (one cycle): copy latched command, sample, shadow gains to pid_* outputs, pid_start=1, -> WAIT with timeout counter=0.
REQ-025 sensor_valid coincident with ISSUE SHALL set fresh again; pid_data carries the previously latched sample.
REQ-026 WAIT + pid_done: out_throttle<=pid_result, out_valid=1 for one cycle (next cycle), -> IDLE.
REQ-027 WAIT: counter increments per cycle; reaching 16 cycles without pid_done sets timeout_fault -> FAULT; pid_done on cycle 16 wins over timeout.
REQ-028 tick in ISSUE or WAIT SHALL increment overrun_cnt, saturating at 255, and not queue a request.
REQ-029 pid_done outside WAIT SHALL be ignored.
REQ-030 FAULT: pid_reset=1, out_throttle=0, pid_start=0; leave only when enable=0 -> DISABLED, clearing both fault flags and miss counter.
REQ-031 pid_reset SHALL be 0 only in IDLE, ISSUE, WAIT.
REQ-032 pid_* data and gain outputs SHALL hold between issues.

Reset
REQ-033 On reset: state DISABLED, pid_reset=1, pid_start=0, out_valid=0, out_throttle=0, faults=0, overrun_cnt=0, fresh=0, counters=0, latched cmd=0, sample=0.
REQ-034 On reset: shadow and active gains kp=16, ki=0, kd=0.
REQ-035 Reset mid-WAIT SHALL abandon the request; a later pid_done SHALL produce no out_valid.

Verification
REQ-036 enable=1, cmd=100, sample 1500, tick -> pid_start one cycle later with pid_command=100, pid_data=1500, kp=16; pid_done result 320 -> out_valid pulse, out_throttle=320.
REQ-037 cfg writes kp=40 while WAIT -> pid_kp stays 16 for current issue, 40 at next ISSUE.
REQ-038 four ticks with no sensor_valid -> stale_fault=1, pid_reset=1, out_throttle=0; enable low one cycle -> flags clear, DISABLED.
REQ-039 no pid_done for 16 cycles after start -> timeout_fault=1, FAULT; pid_done on exactly cycle 16 -> normal completion, no fault.
REQ-040 300 ticks during WAIT -> overrun_cnt=255, no extra pid_start.
REQ-041 reset asserted during WAIT then pid_done -> out_valid stays 0, all outputs at reset values.
